spi_reg_bank: RTL and testbench

Register bank that sits directly downstream of the SPI slave front-end. It consumes the decoded address, write data and write strobe, and returns read data plus an 8-bit status byte for the front-end to shift out. It holds control and configuration registers that drive the rest of the design, a synchronised read-only input register, and a sticky write-1-to-clear event register with an interrupt output.

---
 rtl/spi_reg_bank.sv | 143 ++++++++++++++
 tb/tb_spi_reg_bank.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_bank.sv
// rtl/spi_reg_bank.sv - SPI register bank: control/config registers, synchronised inputs, W1C events, irq
// Sits behind the SPI slave front-end; every output is driven from a flop.
module spi_reg_bank #(
   parameter int ADDR_W = 3,
   parameter int REG_W  = 8
) (
   input  logic                 clk,
   input  logic                 rstb,
   input  logic                 ena,
   input  logic [ADDR_W-1:0]    reg_addr,
   input  logic [REG_W-1:0]     reg_wdata,
   input  logic                 reg_wdata_dv,
   output logic [REG_W-1:0]     reg_rdata,
   output logic [7:0]           status,
   input  logic [REG_W-1:0]     hw_in,
   input  logic [REG_W-1:0]     event_in,
   output logic [REG_W-1:0]     ctrl_o,
   output logic [4*REG_W-1:0]   cfg_o,
   output logic                 irq_o
);

   localparam logic [2:0] A_CTRL  = 3'd0;
   localparam logic [2:0] A_CFG0  = 3'd1;
   localparam logic [2:0] A_CFG1  = 3'd2;
   localparam logic [2:0] A_CFG2  = 3'd3;
   localparam logic [2:0] A_CFG3  = 3'd4;
   localparam logic [2:0] A_HWIN  = 3'd5;
   localparam logic [2:0] A_EVENT = 3'd6;
   localparam logic [2:0] A_IRQEN = 3'd7;

   // CTRL bit 7 is a command strobe, never stored
   localparam logic [REG_W-1:0] CTRL_MASK = ~(REG_W'(8'h80));

   logic [REG_W-1:0]          ctrl_r;
   logic [3:0][REG_W-1:0]     cfg_r;
   logic [REG_W-1:0]          irqen_r;
   logic [REG_W-1:0]          evt_r;
   logic [REG_W-1:0]          hw_sync1;
   logic [REG_W-1:0]          hw_sync2;
   logic [REG_W-1:0]          ev_sync1;
   logic [REG_W-1:0]          ev_sync2;
   logic [REG_W-1:0]          ev_prev;
   logic [2:0]                wr_cnt;
   logic                      err_r;
   logic                      irq_r;
   logic [REG_W-1:0]          rdata_r;

   logic [ADDR_W:0]           addr_ext;
   logic                      addr_oob;
   logic [2:0]                addr_lo;
   logic                      wr_en;
   logic                      wr_illegal;
   logic                      wr_ok;
   logic                      err_clr;
   logic [REG_W-1:0]          evt_edge;
   logic [REG_W-1:0]          evt_clr;
   logic [REG_W-1:0]          evt_next;
   logic [REG_W-1:0]          rd_next;

   assign addr_ext   = {1'b0, reg_addr};
   assign addr_oob   = (addr_ext >> 3) != '0;
   assign addr_lo    = reg_addr[2:0];

   assign wr_en      = reg_wdata_dv & ena;
   assign wr_illegal = wr_en & (addr_oob | (addr_lo == A_HWIN));
   assign wr_ok      = wr_en & ~wr_illegal;
   assign err_clr    = wr_ok & (addr_lo == A_CTRL) & reg_wdata[7];

   // A freshly detected edge overrides a same-cycle W1C on that bit
   assign evt_edge   = ev_sync2 & ~ev_prev;
   assign evt_clr    = (wr_ok && addr_lo == A_EVENT) ? reg_wdata : '0;
   assign evt_next   = (evt_r & ~evt_clr) | evt_edge;

   always_comb begin
      rd_next = '0;
      if (!addr_oob) begin
         case (addr_lo)
            A_CTRL:  rd_next = ctrl_r & CTRL_MASK;
            A_CFG0:  rd_next = cfg_r[0];
            A_CFG1:  rd_next = cfg_r[1];
            A_CFG2:  rd_next = cfg_r[2];
            A_CFG3:  rd_next = cfg_r[3];
            A_HWIN:  rd_next = hw_sync2;
            A_EVENT: rd_next = evt_r;
            A_IRQEN: rd_next = irqen_r;
            default: rd_next = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rstb) begin
         ctrl_r   <= '0;
         cfg_r    <= '0;
         irqen_r  <= '0;
         evt_r    <= '0;
         hw_sync1 <= '0;
         hw_sync2 <= '0;
         ev_sync1 <= '0;
         ev_sync2 <= '0;
         ev_prev  <= '0;
         wr_cnt   <= '0;
         err_r    <= 1'b0;
         irq_r    <= 1'b0;
         rdata_r  <= '0;
      end else if (ena) begin
         hw_sync1 <= hw_in;
         hw_sync2 <= hw_sync1;
         ev_sync1 <= event_in;
         ev_sync2 <= ev_sync1;
         ev_prev  <= ev_sync2;
         evt_r    <= evt_next;
         irq_r    <= |(evt_r & irqen_r);
         rdata_r  <= rd_next;

         if (wr_ok) begin
            wr_cnt <= wr_cnt + 3'd1;
            case (addr_lo)
               A_CTRL:  ctrl_r   <= reg_wdata & CTRL_MASK;
               A_CFG0:  cfg_r[0] <= reg_wdata;
               A_CFG1:  cfg_r[1] <= reg_wdata;
               A_CFG2:  cfg_r[2] <= reg_wdata;
               A_CFG3:  cfg_r[3] <= reg_wdata;
               A_IRQEN: irqen_r  <= reg_wdata;
               default: ;
            endcase
         end

         if (wr_illegal) begin
            err_r <= 1'b1;
         end else if (err_clr) begin
            err_r <= 1'b0;
         end
      end
   end

   assign reg_rdata = rdata_r;
   assign ctrl_o    = ctrl_r;
   assign cfg_o     = cfg_r;
   assign irq_o     = irq_r;
   assign status    = {irq_r, err_r, 3'b000, wr_cnt};

endmodule

// File: tb/tb_spi_reg_bank.sv
// tb/tb_spi_reg_bank.sv - self-checking bench for spi_reg_bank
module tb_spi_reg_bank;

   logic        clk = 1'b0;
   logic        rstb;
   logic        ena;
   logic [2:0]  reg_addr;
   logic [7:0]  reg_wdata;
   logic        reg_wdata_dv;
   logic [7:0]  reg_rdata;
   logic [7:0]  status;
   logic [7:0]  hw_in;
   logic [7:0]  event_in;
   logic [7:0]  ctrl_o;
   logic [31:0] cfg_o;
   logic        irq_o;

   int          checks = 0;
   int          failures = 0;
   int          m_cnt = 0;
   logic [7:0]  m_cfg0 = 8'h00;
   logic [7:0]  exp_q[$];
   string       name_q[$];

   localparam logic [7:0] HW_VAL = 8'h3C;

   always #5 clk = ~clk;

   spi_reg_bank #(.ADDR_W(3), .REG_W(8)) dut (
      .clk(clk), .rstb(rstb), .ena(ena),
      .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wdata_dv(reg_wdata_dv),
      .reg_rdata(reg_rdata), .status(status),
      .hw_in(hw_in), .event_in(event_in),
      .ctrl_o(ctrl_o), .cfg_o(cfg_o), .irq_o(irq_o)
   );

   task automatic do_write(input logic [2:0] a, input logic [7:0] d);
      @(negedge clk);
      reg_addr = a;
      reg_wdata = d;
      reg_wdata_dv = 1'b1;
      @(negedge clk);
      reg_wdata_dv = 1'b0;
      if (a != 3'd5) m_cnt = (m_cnt + 1) % 8;
   endtask

   // Expected data is queued with the address; popped once rdata is due
   task automatic do_read(input logic [2:0] a, input logic [7:0] e, input string nm);
      logic [7:0] x;
      string      n;
      @(negedge clk);
      reg_addr = a;
      exp_q.push_back(e);
      name_q.push_back(nm);
      @(negedge clk);
      x = exp_q.pop_front();
      n = name_q.pop_front();
      checks++;
      if (reg_rdata !== x) begin
         failures++;
         $display("FAIL %s: got %h expected %h", n, reg_rdata, x);
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rstb = 1'b0;
      ena = 1'($urandom);
      reg_addr = 3'($urandom);
      reg_wdata = 8'($urandom);
      reg_wdata_dv = 1'($urandom);
      hw_in = 8'($urandom);
      event_in = 8'($urandom);
      repeat (2) @(negedge clk);
      checks++;
      if (reg_rdata !== 8'h00) begin failures++; $display("FAIL rst_rdata: got %h expected 00", reg_rdata); end
      checks++;
      if (status !== 8'h00) begin failures++; $display("FAIL rst_status: got %h expected 00", status); end
      checks++;
      if (ctrl_o !== 8'h00) begin failures++; $display("FAIL rst_ctrl: got %h expected 00", ctrl_o); end
      checks++;
      if (cfg_o !== 32'h0) begin failures++; $display("FAIL rst_cfg: got %h expected 0", cfg_o); end
      checks++;
      if (irq_o !== 1'b0) begin failures++; $display("FAIL rst_irq: got %b expected 0", irq_o); end
      ena = 1'b1;
      reg_wdata_dv = 1'b0;
      event_in = 8'h00;
      hw_in = HW_VAL;
      rstb = 1'b1;
      m_cnt = 0;
      m_cfg0 = 8'h00;
   endtask

   task automatic test_reset();
      apply_reset();
      repeat (3) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         do_read(3'(i), (i == 5) ? HW_VAL : 8'h00, $sformatf("rst_read%0d", i));
      end
   endtask

   task automatic test_rw();
      do_write(3'd3, 8'hA5);
      checks++;
      if (cfg_o[23:16] !== 8'hA5) begin failures++; $display("FAIL cfg2_out: got %h expected a5", cfg_o[23:16]); end
      do_read(3'd3, 8'hA5, "cfg2_read");
      do_write(3'd0, 8'hFF);
      checks++;
      if (ctrl_o !== 8'h7F) begin failures++; $display("FAIL ctrl_out: got %h expected 7f", ctrl_o); end
      do_read(3'd0, 8'h7F, "ctrl_read");
      checks++;
      if (status[2:0] !== 3'(m_cnt)) begin failures++; $display("FAIL rw_cnt: got %0d expected %0d", status[2:0], m_cnt); end
   endtask

   task automatic test_wrap();
      apply_reset();
      for (int i = 0; i < 9; i++) begin
         do_write(3'd1, 8'(i));
      end
      m_cfg0 = 8'h08;
      checks++;
      if (status[2:0] !== 3'd1) begin failures++; $display("FAIL cnt_wrap: got %0d expected 1", status[2:0]); end
      do_read(3'd1, m_cfg0, "cfg0_last");
   endtask

   task automatic test_ro_illegal();
      do_write(3'd5, 8'h12);
      checks++;
      if (status[6] !== 1'b1) begin failures++; $display("FAIL ro_err: got %b expected 1", status[6]); end
      checks++;
      if (status[2:0] !== 3'(m_cnt)) begin failures++; $display("FAIL ro_cnt: got %0d expected %0d", status[2:0], m_cnt); end
      do_read(3'd5, HW_VAL, "hwin_unchanged");
      do_write(3'd0, 8'h80);
      checks++;
      if (status[6] !== 1'b0) begin failures++; $display("FAIL err_clr: got %b expected 0", status[6]); end
      checks++;
      if (ctrl_o !== 8'h00) begin failures++; $display("FAIL ctrl_selfclr: got %h expected 00", ctrl_o); end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      reg_addr = 3'd5;
      reg_wdata = 8'h00;
      reg_wdata_dv = 1'b1;
      @(negedge clk);
      checks++;
      if (status[6] !== 1'b1) begin failures++; $display("FAIL b2b_set: got %b expected 1", status[6]); end
      reg_addr = 3'd0;
      reg_wdata = 8'h80;
      @(negedge clk);
      reg_wdata_dv = 1'b0;
      m_cnt = (m_cnt + 1) % 8;
      checks++;
      if (status[6] !== 1'b0) begin failures++; $display("FAIL b2b_clr: got %b expected 0", status[6]); end
      checks++;
      if (status[2:0] !== 3'(m_cnt)) begin failures++; $display("FAIL b2b_cnt: got %0d expected %0d", status[2:0], m_cnt); end
   endtask

   task automatic test_events();
      do_write(3'd7, 8'h04);
      @(negedge clk);
      event_in = 8'h04;
      reg_addr = 3'd6;
      repeat (3) @(negedge clk);
      checks++;
      if (irq_o !== 1'b0) begin failures++; $display("FAIL irq_early: got %b expected 0", irq_o); end
      @(negedge clk);
      event_in = 8'h00;
      checks++;
      if (irq_o !== 1'b1) begin failures++; $display("FAIL irq_rise: got %b expected 1", irq_o); end
      checks++;
      if (status[7] !== 1'b1) begin failures++; $display("FAIL stat_irq: got %b expected 1", status[7]); end
      checks++;
      if (reg_rdata !== 8'h04) begin failures++; $display("FAIL evt_set: got %h expected 04", reg_rdata); end
      do_write(3'd6, 8'h04);
      checks++;
      if (irq_o !== 1'b1) begin failures++; $display("FAIL irq_hold: got %b expected 1", irq_o); end
      @(negedge clk);
      checks++;
      if (irq_o !== 1'b0) begin failures++; $display("FAIL irq_fall: got %b expected 0", irq_o); end
      do_read(3'd6, 8'h00, "evt_w1c");
      @(negedge clk);
      event_in = 8'h01;
      repeat (5) @(negedge clk);
      checks++;
      if (irq_o !== 1'b0) begin failures++; $display("FAIL irq_masked: got %b expected 0", irq_o); end
      do_read(3'd6, 8'h01, "evt_masked");
   endtask

   task automatic test_collision();
      @(negedge clk);
      event_in = 8'h03;
      repeat (2) @(negedge clk);
      reg_addr = 3'd6;
      reg_wdata = 8'h02;
      reg_wdata_dv = 1'b1;
      @(negedge clk);
      reg_wdata_dv = 1'b0;
      m_cnt = (m_cnt + 1) % 8;
      do_read(3'd6, 8'h03, "evt_collide");
      event_in = 8'h00;
      do_write(3'd6, 8'h03);
      do_read(3'd6, 8'h00, "evt_clear_all");
   endtask

   task automatic test_ena();
      @(negedge clk);
      ena = 1'b0;
      reg_addr = 3'd1;
      reg_wdata = 8'h55;
      reg_wdata_dv = 1'b1;
      event_in = 8'h08;
      @(negedge clk);
      reg_wdata_dv = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if (cfg_o[7:0] !== m_cfg0) begin failures++; $display("FAIL ena_cfg: got %h expected %h", cfg_o[7:0], m_cfg0); end
      checks++;
      if (status !== {5'b00000, 3'(m_cnt)}) begin failures++; $display("FAIL ena_status: got %h expected %h", status, {5'b00000, 3'(m_cnt)}); end
      ena = 1'b1;
      repeat (2) @(negedge clk);
      do_read(3'd6, 8'h08, "ena_evt_late");
      checks++;
      if (irq_o !== 1'b0) begin failures++; $display("FAIL ena_irq: got %b expected 0", irq_o); end
   endtask

   initial begin
      rstb = 1'b1;
      ena = 1'b1;
      reg_addr = '0;
      reg_wdata = '0;
      reg_wdata_dv = 1'b0;
      hw_in = '0;
      event_in = '0;
      test_reset();
      test_rw();
      test_wrap();
      test_ro_illegal();
      test_back_to_back();
      test_events();
      test_collision();
      test_ena();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
